// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// PC increment and the bit positions of every instruction-register field.
package fetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } fetch_state_e;

   localparam logic [31:0] PC_INCR = 32'd4;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 24;
   localparam int OFFSET_MSB = 23;
   localparam int OFFSET_LSB = 16;
   localparam int DEST_MSB   = 18;
   localparam int DEST_LSB   = 16;
   localparam int SRC1_MSB   = 10;
   localparam int SRC1_LSB   = 8;
   localparam int SRC2_MSB   = 2;
   localparam int SRC2_LSB   = 0;
   localparam int IMM_MSB    = 7;
   localparam int IMM_LSB    = 0;

   // Signed word offset converted to a byte displacement.
   function automatic logic [31:0] offset_to_bytes(input logic [7:0] offset);
      return {{22{offset[7]}}, offset, 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next program counter: sequential PC+4, plus the sign-extended word offset
// when a jump is requested or a branch-if-equal sees ZERO set.
module pc_next_calc
   import fetch_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [7:0]  offset_i,
   input  logic        jump_i,
   input  logic        branch_i,
   input  logic        zero_i,
   output logic [31:0] next_pc_o
);

   logic        take;
   logic [31:0] disp;

   // JUMP wins over BRANCH simply because either one enables the same offset.
   assign take      = jump_i | (branch_i & zero_i);
   assign disp      = take ? offset_to_bytes(offset_i) : 32'd0;
   assign next_pc_o = pc_i + PC_INCR + disp;

endmodule

// File: rtl/instr_fetch_unit.sv
// Two-state fetch/execute sequencer: latches an instruction word while memory
// is ready, presents its decoded fields during EXEC, then advances the PC.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTR_IN,
   input  logic        BUSYWAIT,
   input  logic        DSTALL,
   input  logic        JUMP,
   input  logic        BRANCH,
   input  logic        ZERO,
   output logic [31:0] PC,
   output logic        INSTR_READ,
   output logic        VALID,
   output logic [7:0]  OPCODE,
   output logic [2:0]  INADDRESS,
   output logic [2:0]  OUT1ADDRESS,
   output logic [2:0]  OUT2ADDRESS,
   output logic [7:0]  IMMEDIATE
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ir_q, ir_d;
   logic [31:0]  next_pc;
   logic         ir_unused;

   pc_next_calc u_pc_next_calc (
      .pc_i      (pc_q),
      .offset_i  (ir_q[OFFSET_MSB:OFFSET_LSB]),
      .jump_i    (JUMP),
      .branch_i  (BRANCH),
      .zero_i    (ZERO),
      .next_pc_o (next_pc)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Control inputs only matter on the EXEC edge that actually retires.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         FETCH: begin
            if (!BUSYWAIT) begin
               ir_d    = INSTR_IN;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (!DSTALL) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // Handshake flags are forced low for the whole time RESET is held.
   assign INSTR_READ  = (state_q == FETCH) & ~RESET;
   assign VALID       = (state_q == EXEC) & ~RESET;
   assign PC          = pc_q;

   assign OPCODE      = ir_q[OPCODE_MSB:OPCODE_LSB];
   assign INADDRESS   = ir_q[DEST_MSB:DEST_LSB];
   assign OUT1ADDRESS = ir_q[SRC1_MSB:SRC1_LSB];
   assign OUT2ADDRESS = ir_q[SRC2_MSB:SRC2_LSB];
   assign IMMEDIATE   = ir_q[IMM_MSB:IMM_LSB];

   assign ir_unused   = ^ir_q[15:11];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural fetch/execute model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        busywait, dstall, jump, branch, zero;
  logic [31:0] pc;
  logic        instr_read, valid;
  logic [7:0]  opcode, immediate;
  logic [2:0]  inaddress, out1address, out2address;

  instr_fetch_unit dut (
    .CLK         (clk),
    .RESET       (rst),
    .INSTR_IN    (instr_in),
    .BUSYWAIT    (busywait),
    .DSTALL      (dstall),
    .JUMP        (jump),
    .BRANCH      (branch),
    .ZERO        (zero),
    .PC          (pc),
    .INSTR_READ  (instr_read),
    .VALID       (valid),
    .OPCODE      (opcode),
    .INADDRESS   (inaddress),
    .OUT1ADDRESS (out1address),
    .OUT2ADDRESS (out2address),
    .IMMEDIATE   (immediate)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  bit          m_exec;       // model: an instruction is held and being executed
  bit          m_first;      // model: first observation of this EXEC period
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  int          valid_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [24:0] fields_of(input logic [31:0] w);
    return {w[31:24], w[18:16], w[10:8], w[2:0], w[7:0]};
  endfunction

  task automatic model_reset();
    m_exec  = 1'b0;
    m_first = 1'b0;
    m_pc    = 32'h0;
    m_ir    = 32'h0;
    exp_q.delete();
  endtask

  // One rising edge of the specified behaviour, using the inputs the bench drove.
  task automatic model_edge();
    longint t;
    int     off;
    if (!m_exec) begin
      if (!busywait) begin
        m_ir    = instr_in;
        m_exec  = 1'b1;
        m_first = 1'b1;
        exp_q.push_back(instr_in);
      end
    end else if (!dstall) begin
      off = int'($signed(m_ir[23:16]));
      t   = longint'(m_pc) + 4;
      if (jump || (branch && zero)) t = t + 4 * off;
      m_pc   = t[31:0];
      m_exec = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] w;
    check_eq("pc", pc, m_pc);
    check_eq("valid", {31'd0, valid}, {31'd0, m_exec});
    check_eq("instr_read", {31'd0, instr_read}, {31'd0, !m_exec});
    if (valid) valid_cnt++;
    if (m_exec) begin
      if (m_first) begin
        m_first = 1'b0;
        if (exp_q.size() == 0) begin
          check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check_eq("fields_new", {7'd0, opcode, inaddress, out1address, out2address, immediate},
                   {7'd0, fields_of(w)});
        end
      end else begin
        check_eq("fields_hold", {7'd0, opcode, inaddress, out1address, out2address, immediate},
                 {7'd0, fields_of(m_ir)});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit bw, input bit ds, input bit j, input bit b, input bit z,
                       input logic [31:0] w);
    busywait = bw;
    dstall   = ds;
    jump     = j;
    branch   = b;
    zero     = z;
    instr_in = w;
  endtask

  task automatic step(input bit bw, input bit ds, input bit j, input bit b, input bit z,
                      input logic [31:0] w);
    drive(bw, ds, j, b, z, w);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Plain instruction: fetch then execute with no control flow.
  task automatic run_plain(input logic [31:0] w);
    step(0, 0, 0, 0, 0, w);
    step(0, 0, 0, 0, 0, 32'h0);
  endtask

  // Asynchronous reset pulse between edges; EXEC is stalled at the preceding edge.
  task automatic reset_pulse();
    drive(1, 1, 0, 0, 0, $urandom);
    @(posedge clk);
    model_edge();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_instr_read", {31'd0, instr_read}, 32'd0);
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0);
    model_reset();
    #2;
    check_eq("in_reset_pc", pc, 32'h0);
    check_eq("in_reset_valid", {31'd0, valid}, 32'd0);
    check_eq("in_reset_instr_read", {31'd0, instr_read}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_held_pc", pc, 32'h0);
    check_eq("reset_held_instr_read", {31'd0, instr_read}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("release_instr_read", {31'd0, instr_read}, 32'd1);

    // Straight-line sequence 0,4,8 with VALID every second cycle.
    valid_cnt = 0;
    run_plain(32'h1100_0000);
    check_eq("seq_pc4", pc, 32'd4);
    run_plain(32'h1200_0000);
    check_eq("seq_pc8", pc, 32'd8);
    check_eq("seq_valid_cycles", valid_cnt, 32'd2);

    // Backward jump from 8 with offset -2 lands on 4.
    step(0, 0, 0, 0, 0, 32'h00FE_0000);
    step(0, 0, 1, 0, 0, 32'h0);
    check_eq("jump_back", pc, 32'd4);

    // Jump from 4 with offset -3 lands on FFFF_FFFC, then wrap to 0.
    step(0, 0, 0, 0, 0, 32'h00FD_0000);
    step(0, 0, 1, 1, 0, 32'h0);
    check_eq("jump_top", pc, 32'hFFFF_FFFC);
    valid_cnt = 0;
    step(0, 0, 0, 0, 0, 32'h0000_0000);
    step(0, 1, 1, 1, 1, 32'h0);
    step(0, 1, 1, 0, 0, 32'h0);
    check_eq("dstall_pc_hold", pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 32'h0);
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("dstall_valid_cycles", valid_cnt, 32'd3);

    // Taken branch from 8 with offset 3 lands on 24.
    run_plain(32'h0);
    run_plain(32'h0);
    step(0, 0, 0, 0, 0, 32'h0003_0000);
    step(0, 0, 0, 1, 1, 32'h0);
    check_eq("branch_taken", pc, 32'd24);

    // Jump back to 8 (offset -5), then not-taken branch gives 12.
    step(0, 0, 0, 0, 0, 32'h00FB_0000);
    step(0, 0, 1, 0, 0, 32'h0);
    check_eq("jump_to8", pc, 32'd8);
    step(0, 0, 0, 0, 0, 32'h0003_0000);
    step(0, 0, 0, 1, 0, 32'h0);
    check_eq("branch_not_taken", pc, 32'd12);

    // Memory busy for three cycles, then one load of the waiting word.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 1, 32'h0002_0105);
      check_eq("busy_pc_hold", pc, 32'd12);
    end
    step(0, 0, 0, 0, 0, 32'h0002_0105);
    check_eq("dec_opcode", {24'd0, opcode}, 32'd0);
    check_eq("dec_inaddress", {29'd0, inaddress}, 32'd2);
    check_eq("dec_out1address", {29'd0, out1address}, 32'd1);
    check_eq("dec_out2address", {29'd0, out2address}, 32'd5);
    check_eq("dec_immediate", {24'd0, immediate}, 32'd5);
    step(0, 0, 0, 0, 0, 32'h0);
    check_eq("after_busy_pc", pc, 32'd16);

    // Reset during EXEC at PC 20.
    run_plain(32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    check_eq("pre_reset_pc", pc, 32'd20);
    reset_pulse();

    // Randomized traffic, with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse();
      end else begin
        step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
